// File: rtl/prewitt_pkg.sv
// Shared definitions for the Prewitt window front end: FSM state encoding,
// default frame geometry and a counter-width helper.
package prewitt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_STREAM = 2'd2
  } lb_state_e;

  localparam int DEF_PIC_WIDTH  = 250;
  localparam int DEF_PIC_HEIGHT = 250;
  localparam int DEF_WIDTH      = 24;

  // Bits needed to count 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prewitt_line_buffer_ram.sv
// lb_line_ram: simple dual-port line RAM with one write port and one
// registered read port. A read and a write to the same address in the same
// cycle return the old contents (read-before-write). Only the read register
// is reset; the array keeps whatever it held.
module lb_line_ram #(
  parameter int DEPTH = 250,
  parameter int DW    = 24,
  parameter int AW    = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q;

  // Write port.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Registered read port; holds its value when no read is issued.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   rdata_q <= '0;
    else if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/prewitt_line_buffer.sv
// prewitt_line_buffer: two-line buffer in front of the 3x3 Prewitt matrix.
// Presents a vertically aligned column (row1 = two lines up, row2 = one line
// up, row3 = current) one cycle after each accepted pixel.
// Optional build macro PREWITT_LB_GRAY_STORE_EN: store and emit only the low
// byte of each pixel, replicated to three channels (WIDTH must be 24).
//
// Handshake: a beat is offered when valid_in is 1. It is accepted when the
// FSM is active or the beat carries sof; in IDLE, beats without sof are
// dropped. There is no backpressure. valid_out is a one-cycle qualifier for
// row1..row3, eol_out and eof_out, asserted the cycle after an accepted beat
// that completes a full 3-row column.
module prewitt_line_buffer
  import prewitt_pkg::*;
#(
  parameter int PIC_WIDTH  = DEF_PIC_WIDTH,
  parameter int PIC_HEIGHT = DEF_PIC_HEIGHT,
  parameter int WIDTH      = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic             sof,
  input  logic [WIDTH-1:0] din,
  output logic             valid_out,
  output logic [WIDTH-1:0] row1,
  output logic [WIDTH-1:0] row2,
  output logic [WIDTH-1:0] row3,
  output logic             eol_out,
  output logic             eof_out
);

  localparam int CW = cnt_w(PIC_WIDTH);
  localparam int LW = cnt_w(PIC_HEIGHT);

`ifdef PREWITT_LB_GRAY_STORE_EN
  localparam int SW = 8;
  if (WIDTH != 24) begin : g_bad_width
    $error("PREWITT_LB_GRAY_STORE_EN requires WIDTH == 24");
  end
`else
  localparam int SW = WIDTH;
`endif

  lb_state_e     state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [LW-1:0] line_q, line_d;
  logic [CW-1:0] prev_col_q;
  logic          pend_q;
  logic          valid_q, eol_q, eof_q;
  logic [SW-1:0] row3_q;
  logic [SW-1:0] store_w, rd_a, rd_b;

  logic          accept;
  lb_state_e     cur_state;
  logic [CW-1:0] cur_col;
  logic [LW-1:0] cur_line;
  logic          last_col, last_line, in_stream;

`ifdef PREWITT_LB_GRAY_STORE_EN
  assign store_w = din[7:0];
  assign row1    = {3{rd_b}};
  assign row2    = {3{rd_a}};
  assign row3    = {3{row3_q}};
`else
  assign store_w = din;
  assign row1    = rd_b;
  assign row2    = rd_a;
  assign row3    = row3_q;
`endif

  // A sof beat is always pixel (0,0) of a new frame, whatever state we are in.
  assign accept    = valid_in & (sof | (state_q != ST_IDLE));
  assign cur_state = sof ? ST_FILL : state_q;
  assign cur_col   = sof ? '0 : col_q;
  assign cur_line  = sof ? '0 : line_q;
  assign last_col  = (cur_col == CW'(PIC_WIDTH - 1));
  assign last_line = (cur_line == LW'(PIC_HEIGHT - 1));
  assign in_stream = (cur_state == ST_STREAM);

  // Next raster position and FSM state for an accepted beat.
  always_comb begin
    col_d   = col_q;
    line_d  = line_q;
    state_d = state_q;
    if (accept) begin
      state_d = cur_state;
      col_d   = last_col ? '0 : cur_col + 1'b1;
      line_d  = cur_line;
      if (last_col) begin
        line_d = last_line ? '0 : cur_line + 1'b1;
        if (cur_state == ST_FILL && cur_line == LW'(1)) state_d = ST_STREAM;
        if (cur_state == ST_STREAM && last_line)         state_d = ST_IDLE;
      end
    end
  end

  // FSM, counters, output flags and the current-row register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      col_q      <= '0;
      line_q     <= '0;
      prev_col_q <= '0;
      pend_q     <= 1'b0;
      valid_q    <= 1'b0;
      eol_q      <= 1'b0;
      eof_q      <= 1'b0;
      row3_q     <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      line_q  <= line_d;
      valid_q <= accept & in_stream;
      eol_q   <= accept & in_stream & last_col;
      eof_q   <= accept & in_stream & last_col & last_line;
      if (accept) begin
        prev_col_q <= cur_col;
        pend_q     <= 1'b1;
        row3_q     <= store_w;
      end
    end
  end

  assign valid_out = valid_q;
  assign eol_out   = eol_q;
  assign eof_out   = eof_q;

  // Line one above: written with the incoming pixel, read at the same column.
  lb_line_ram #(.DEPTH(PIC_WIDTH), .DW(SW), .AW(CW)) u_ram_a (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .we_i    (accept),
    .waddr_i (cur_col),
    .wdata_i (store_w),
    .re_i    (accept),
    .raddr_i (cur_col),
    .rdata_o (rd_a)
  );

  // Line two above: RAM_A's registered read data is written one accepted beat
  // later at the previous column, which is always after that column's read.
  lb_line_ram #(.DEPTH(PIC_WIDTH), .DW(SW), .AW(CW)) u_ram_b (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .we_i    (accept & pend_q),
    .waddr_i (prev_col_q),
    .wdata_i (rd_a),
    .re_i    (accept),
    .raddr_i (cur_col),
    .rdata_o (rd_b)
  );

endmodule

// File: tb/tb_prewitt_line_buffer.sv
// Directed bench for prewitt_line_buffer on a 4x4 frame, pixel = {3{line*16+col}}
// plus a per-frame base offset so stale data from an aborted frame is visible.
module tb_prewitt_line_buffer;
  import prewitt_pkg::*;

  localparam int PW = 4;
  localparam int PH = 4;
  localparam int W  = 24;

  // Clock / reset block
  logic         clk = 1'b0;
  logic         rst_n;
  logic         valid_in;
  logic         sof;
  logic [W-1:0] din;
  logic         valid_out;
  logic [W-1:0] row1, row2, row3;
  logic         eol_out, eof_out;

  always #5 clk = ~clk;

  prewitt_line_buffer #(.PIC_WIDTH(PW), .PIC_HEIGHT(PH), .WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .sof       (sof),
    .din       (din),
    .valid_out (valid_out),
    .row1      (row1),
    .row2      (row2),
    .row3      (row3),
    .eol_out   (eol_out),
    .eof_out   (eof_out)
  );

  int n_pass  = 0;
  int n_total = 0;
  int n_valid = 0;

  logic [W-1:0] exp_r1, exp_r2, exp_r3;
  bit           rows_known;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [W-1:0] pix(input int l, input int c, input logic [7:0] base);
    logic [7:0] b;
    b = base + 8'(l * 16 + c);
    return {b, b, b};
  endfunction

  // Value put on din for an expected pixel; gray builds get junk upper bytes.
  function automatic logic [W-1:0] drive_val(input logic [W-1:0] p);
`ifdef PREWITT_LB_GRAY_STORE_EN
    return {16'hAB12, p[7:0]};
`else
    return p;
`endif
  endfunction

  // Driver tasks
  task automatic beat(input logic v, input logic s, input logic [W-1:0] d);
    valid_in = v;
    sof      = s;
    din      = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send_pix(input int l, input int c, input logic [7:0] base, input bit s);
    logic [W-1:0] p;
    bit strm;
    p    = pix(l, c, base);
    strm = (l >= 2);
    beat(1'b1, s, drive_val(p));
    chk("valid_out", {23'd0, valid_out}, {23'd0, strm});
    chk("row3", row3, p);
    chk("eol_out", {23'd0, eol_out}, {23'd0, strm && c == PW - 1});
    chk("eof_out", {23'd0, eof_out}, {23'd0, strm && c == PW - 1 && l == PH - 1});
    if (strm) begin
      chk("row1", row1, pix(l - 2, c, base));
      chk("row2", row2, pix(l - 1, c, base));
      exp_r1 = pix(l - 2, c, base);
      exp_r2 = pix(l - 1, c, base);
      n_valid++;
    end
    exp_r3     = p;
    rows_known = strm;
  endtask

  task automatic gap();
    beat(1'b0, 1'($urandom_range(0, 1)), W'($urandom));
    chk("gap_valid", {23'd0, valid_out}, 24'd0);
    chk("gap_eol", {23'd0, eol_out}, 24'd0);
    chk("gap_eof", {23'd0, eof_out}, 24'd0);
    chk("gap_row3_hold", row3, exp_r3);
    if (rows_known) begin
      chk("gap_row1_hold", row1, exp_r1);
      chk("gap_row2_hold", row2, exp_r2);
    end
  endtask

  task automatic send_frame(input logic [7:0] base, input bit gaps);
    n_valid = 0;
    for (int l = 0; l < PH; l++) begin
      for (int c = 0; c < PW; c++) begin
        send_pix(l, c, base, (l == 0 && c == 0));
        if (gaps) gap();
      end
    end
    chk("valid_count", 24'(n_valid), 24'd8);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, {23'd0, valid_out}, 24'd0);
    chk({tag, "_row1"}, row1, 24'd0);
    chk({tag, "_row2"}, row2, 24'd0);
    chk({tag, "_row3"}, row3, 24'd0);
    chk({tag, "_eol"}, {23'd0, eol_out}, 24'd0);
    chk({tag, "_eof"}, {23'd0, eof_out}, 24'd0);
    chk({tag, "_state"}, {22'd0, dut.state_q}, {22'd0, ST_IDLE});
  endtask

  initial begin
    rst_n      = 1'b0;
    valid_in   = 1'b0;
    sof        = 1'b0;
    din        = '0;
    rows_known = 1'b0;
    exp_r1 = '0; exp_r2 = '0; exp_r3 = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Basic gapless frame, then the FSM must sit in IDLE and drop non-sof beats
    send_frame(8'h00, 1'b0);
    chk("idle_after_frame", {22'd0, dut.state_q}, {22'd0, ST_IDLE});
    beat(1'b1, 1'b0, pix(1, 1, 8'h00));
    chk("idle_ignore_valid", {23'd0, valid_out}, 24'd0);
    chk("idle_ignore_row3", row3, 24'h333333);

    // Same frame with a gap after every beat
    send_frame(8'h00, 1'b1);

    // Aborted frame (base 0x80) restarted at line 2, col 1
    for (int l = 0; l < 2; l++)
      for (int c = 0; c < PW; c++)
        send_pix(l, c, 8'h80, (l == 0 && c == 0));
    send_pix(2, 0, 8'h80, 1'b0);
    send_frame(8'h00, 1'b0);

    // Async reset in the middle of STREAM
    for (int l = 0; l < 2; l++)
      for (int c = 0; c < PW; c++)
        send_pix(l, c, 8'h40, (l == 0 && c == 0));
    for (int c = 0; c < 3; c++) send_pix(2, c, 8'h40, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      beat(1'b1, 1'b0, pix(3, i, 8'h40));
      chk("post_rst_valid", {23'd0, valid_out}, 24'd0);
      chk("post_rst_row3", row3, 24'd0);
      chk("post_rst_row1", row1, 24'd0);
    end
    exp_r3 = '0;
    rows_known = 1'b0;
    send_frame(8'h00, 1'b0);

    // Back-to-back frames: sof on the beat right after eof
    send_frame(8'h00, 1'b0);
    send_frame(8'h00, 1'b0);

`ifdef PREWITT_LB_GRAY_STORE_EN
    beat(1'b1, 1'b1, 24'hAB1220);
    chk("gray_row3", row3, 24'h202020);
`endif

    valid_in = 1'b0;
    sof      = 1'b0;
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/prewitt_line_buffer.md
# prewitt_line_buffer

Upstream stage of the 3x3 Prewitt window. It takes a raster pixel stream, one pixel per `valid_in` beat, and buffers two full lines. It then presents three vertically aligned pixels (two lines above, one line above, current line) on `row1`/`row2`/`row3`, which drive the matrix stage's `din1`/`din2`/`din3` together with `valid_out`. Frame and line position are tracked so that `valid_out` is raised only once a full 3-row column exists.

## Interface
Parameters:
- `PIC_WIDTH`, 250: pixels per line; RAM depth.
- `PIC_HEIGHT`, 250: lines per frame.
- `WIDTH`, 24: pixel width (RGB888, gray replicated).

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `valid_in`  in  1  input pixel beat.
- `sof`  in  1  start of frame; qualified by `valid_in`; marks pixel (0,0).
- `din`  in  WIDTH  input pixel.
- `valid_out`  out  1  `row1..row3` hold a valid column.
- `row1`  out  WIDTH  pixel two lines above (top row); feeds `din1`.
- `row2`  out  WIDTH  pixel one line above; feeds `din2`.
- `row3`  out  WIDTH  current pixel, delayed 1 cycle; feeds `din3`.
- `eol_out`  out  1  pulse with last valid column of a line.
- `eof_out`  out  1  pulse with last valid column of the frame.

## Operation
- Column counter `col`: 0..PIC_WIDTH-1; advances on each accepted beat; wraps to 0.
- Line counter `line`: 0..PIC_HEIGHT-1; advances when `col` wraps.
- Two line RAMs, each PIC_WIDTH x WIDTH, addressed by `col`, read-before-write on the same beat:
  - RAM_A stores `din`.
  - RAM_B stores RAM_A's read data.
- Registered outputs on an accepted beat: `row3 <= din`, `row2 <=` RAM_A read, `row1 <=` RAM_B read.
- FSM:
  - **IDLE**: ignores beats without `sof`. `valid_in & sof` -> FILL; that pixel is written as (0,0).
  - **FILL** (lines 0,1): writes only; `valid_out` stays 0. Last pixel of line 1 -> STREAM.
  - **STREAM** (lines 2..PIC_HEIGHT-1): `valid_out` is 1 on each accepted beat. Last pixel of line PIC_HEIGHT-1 -> IDLE.
- `valid_in & sof` in any state restarts the frame: counters go to (0,0), state goes to FILL, and that pixel is written as (0,0). Stale RAM contents are never emitted, because FILL suppresses output for two lines.
- `valid_in` low: counters, RAM, `row*` and state hold; `valid_out`, `eol_out` and `eof_out` are 0.
- Reset (async, mid-frame included): state IDLE, `col` = `line` = 0, all outputs 0. RAM contents are not cleared.

## Timing
- Latency: 1 cycle from an accepted `valid_in` beat to the corresponding `valid_out`/`row*`.
- No backpressure; one pixel per cycle sustained.
- `eol_out` = 1 in the same cycle as `valid_out` for `col` = PIC_WIDTH-1 in STREAM.
- `eof_out` = 1 additionally when that beat is also on `line` = PIC_HEIGHT-1.
- A `sof` beat arriving while `eof_out` is being produced is legal: a back-to-back frame has zero gap.

## Configuration
- Macro `PREWITT_LB_GRAY_STORE_EN`.
- Defined:
  - RAMs store only `din[7:0]`, cutting storage to 8 bits per entry.
  - `row1`/`row2` outputs are `{3{byte}}`; `row3` also outputs `{3{din[7:0]}}`.
  - Applies only when WIDTH = 24; other widths are an elaboration error.
- Undefined: full WIDTH-bit storage and pass-through.

## Structure
- Shared package `prewitt_pkg` holds:
  - FSM state enum (IDLE, FILL, STREAM).
  - Default PIC_WIDTH/PIC_HEIGHT/WIDTH constants.
  - Counter-width function `$clog2`-based.
- One sub-module, `lb_line_ram`: simple dual-port RAM, one write and one read port, synchronous read, read-before-write. Instantiated twice.

## Test plan
Bench uses PIC_WIDTH=4, PIC_HEIGHT=4, and pixel = `{3{line*16+col}}`.
- **Basic frame:** one frame, gapless, `sof` on the first beat. Expected:
  - `valid_out` first rises one cycle after pixel 0x20 is accepted, with `row1`=0x000000, `row2`=0x101010, `row3`=0x202020.
  - `valid_out` is asserted for 8 beats total.
- **Line/frame pulses:** same frame. Expected:
  - `eol_out` at columns with `row3` = 0x232323 and 0x333333.
  - `eof_out` only with `row3` = 0x333333; state then returns to IDLE.
- **Input gaps:** `valid_in` toggled 1/0 every cycle. Expected:
  - Output values match the gapless run.
  - `valid_out` is 0 in gap cycles; `row*` hold their values.
- **Frame restart:** `sof` reasserted at line 2, col 1. Expected:
  - `valid_out` is 0 for the next 8 accepted beats.
  - First valid column is then (line 2 of the new frame, col 0).
- **Async reset:** `rst_n` pulsed low mid-STREAM. Expected:
  - All outputs are 0 immediately.
  - Beats without `sof` are ignored until `sof` arrives.
- **Back-to-back frames:** two frames with no gap; `sof` on the beat after `eof_out`. Expected: second frame's output is identical to the first.
- **Gray storage:** repeat the basic frame with `PREWITT_LB_GRAY_STORE_EN` defined and `din` = 0xAB1220. Expected: `row3` = 0x202020.
